fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: ADDR_W, 8, width of the program counter and instruction-memory address.
REQ-002 Parameter: RESET_PC, 0, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset; overrides every other input.
REQ-005 Port: stop  input  1  stall request from the hazard unit (the same signal that drives IF_ID_Reg.stop).
REQ-006 Port: branch_taken  input  1  redirect request resolved downstream.
REQ-007 Port: branch_target  input  ADDR_W  redirect address, sampled when branch_taken=1.
REQ-008 Port: imem_addr  output  ADDR_W  instruction-memory read address; the memory has a 1-cycle synchronous read.
REQ-009 Port: imem_rdata  input  12  instruction-memory data for the address presented on the previous cycle.
REQ-010 Port: instruction_out  output  12  instruction to IF_ID_Reg.instruction_in.
REQ-011 Port: pc_out  output  ADDR_W  address of instruction_out.
REQ-012 Port: valid_out  output  1  instruction_out is a real, correct-path instruction.
REQ-013 Port: halted  output  1  the block is in the HALTED state.
REQ-014 Port: fetch_count  output  16  number of instructions delivered with valid_out=1 and no stall, wrapping modulo 2^16.

Function
REQ-015 Internal registers SHALL be fetch_pc, inflight_pc, inflight_valid, state {RUN, HALTED} and fetch_count.
REQ-016 imem_addr SHALL equal inflight_pc when stop=1 (re-read to hold data stable) and fetch_pc otherwise.
REQ-017 When inflight_valid=1, state=RUN and branch_taken=0, instruction_out SHALL equal imem_rdata; otherwise it SHALL equal NOP_INSTR (12'h000).
REQ-018 valid_out SHALL equal inflight_valid AND state==RUN AND NOT branch_taken; pc_out SHALL equal inflight_pc.
REQ-019 In RUN with stop=0 and branch_taken=0, the block SHALL advance: fetch_pc<=fetch_pc+1, inflight_pc<=fetch_pc, inflight_valid<=1.
REQ-020 The fetch_pc increment SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-021 In RUN with stop=1 and branch_taken=0, fetch_pc, inflight_pc and inflight_valid SHALL hold, and instruction_out, pc_out and valid_out SHALL hold their values across all stall cycles.
REQ-022 In RUN with branch_taken=1, the block SHALL redirect: fetch_pc<=branch_target, inflight_valid<=0. branch_taken SHALL have priority over stop.
REQ-023 A redirect SHALL produce exactly 2 bubble cycles (the redirect cycle and the following one) before the instruction at branch_target appears with valid_out=1.
REQ-024 When valid_out=1, stop=0 and instruction_out==HALT_INSTR (12'hFFF), the HALT SHALL be delivered that cycle and state SHALL become HALTED on the next edge.
REQ-025 In HALTED: all registers except state SHALL be frozen, stop and branch_taken SHALL be ignored, valid_out=0, instruction_out=NOP_INSTR, and halted=1.
REQ-026 HALTED SHALL be left only by reset.
REQ-027 fetch_count SHALL increment on each edge where valid_out=1 and stop=0.
REQ-028 A stall while inflight_valid=0 SHALL keep the bubble, with valid_out=0 for the whole stall.

Reset
REQ-029 On a reset edge the block SHALL load: fetch_pc=RESET_PC, inflight_pc=0, inflight_valid=0, state=RUN, fetch_count=0.
REQ-030 In the first cycle after reset: imem_addr=RESET_PC, instruction_out=12'h000, pc_out=0, valid_out=0, halted=0.
REQ-031 Reset mid-stall, mid-redirect or in HALTED SHALL give the same result as REQ-029.

Structure
REQ-032 cpu_pkg SHALL hold INSTR_W=12, NOP_INSTR, HALT_INSTR and the enum fetch_state_t {RUN, HALTED}.
REQ-033 The block SHALL be a single module with no sub-module; the PC-next mux and the counter are inline.

Verification
REQ-034 The bench SHALL use a 1-cycle synchronous ROM with mem[0..3]={12'h111,12'h222,12'h333,12'h444}, mem[8]=12'hABC and mem[9]=12'hFFF.
REQ-035 Reset, then run 4 cycles -> first cycle valid_out=0; then instruction_out 111,222,333 with pc_out 0,1,2 and valid_out=1.
REQ-036 Assert stop for 3 cycles while 12'h222 is shown -> instruction_out=222, pc_out=1, fetch_count frozen; after release 12'h333 follows with no loss or duplicate.
REQ-037 branch_taken=1 with target 8 while 12'h222 is shown -> 2 cycles of valid_out=0 and 12'h000, then 12'hABC at pc_out=8.
REQ-038 Raise stop and branch_taken in the same cycle -> the redirect wins, with the same response as REQ-037.
REQ-039 Run through mem[9]=12'hFFF -> FFF delivered once with valid_out=1, then halted=1 and valid_out=0 indefinitely even with branch_taken pulsed; reset -> restart at pc 0.
REQ-040 With ADDR_W=2, free-run 6 cycles -> pc_out sequence 0,1,2,3,0,1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, special encodings and fetch-stage state type.
package cpu_pkg;

   localparam int INSTR_W = 12;

   localparam logic [INSTR_W-1:0] NOP_INSTR  = 12'h000;
   localparam logic [INSTR_W-1:0] HALT_INSTR = 12'hFFF;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect, stall hold and HALT detection
// in front of a memory with a 1-cycle synchronous read.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stop,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               valid_out,
   output logic               halted,
   output logic [15:0]        fetch_count
);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight_valid;
   fetch_state_t      state;
   logic [15:0]       fetch_count_q;
   logic              deliver;

   // While stalled the memory re-reads the in-flight address so its data stays put.
   assign imem_addr       = stop ? inflight_pc : fetch_pc;
   assign valid_out       = inflight_valid && (state == RUN) && !branch_taken;
   assign instruction_out = valid_out ? imem_rdata : NOP_INSTR;
   assign pc_out          = inflight_pc;
   assign halted          = (state == HALTED);
   assign fetch_count     = fetch_count_q;
   assign deliver         = valid_out && !stop;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc       <= RESET_PC;
         inflight_pc    <= '0;
         inflight_valid <= 1'b0;
         state          <= RUN;
         fetch_count_q  <= '0;
      end else if (state == RUN) begin
         if (branch_taken) begin
            fetch_pc       <= branch_target;
            inflight_valid <= 1'b0;
         end else if (!stop) begin
            fetch_pc       <= fetch_pc + ADDR_W'(1);
            inflight_pc    <= fetch_pc;
            inflight_valid <= 1'b1;
         end
         if (deliver) begin
            fetch_count_q <= fetch_count_q + 16'd1;
            if (instruction_out == HALT_INSTR) begin
               state <= HALTED;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios on a small ROM plus a randomized run
// checked against an instruction-stream scoreboard.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stop = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic [7:0]  imem_addr;
   logic [11:0] imem_rdata = 12'h000;
   logic [11:0] instruction_out;
   logic [7:0]  pc_out;
   logic        valid_out;
   logic        halted;
   logic [15:0] fetch_count;

   logic        stop2 = 1'b0;
   logic        branch2 = 1'b0;
   logic [1:0]  target2 = 2'b00;
   logic [1:0]  imem_addr2;
   logic [11:0] imem_rdata2 = 12'h000;
   logic [11:0] instr2;
   logic [1:0]  pc2;
   logic        valid2;
   logic        halted2;
   logic [15:0] count2;

   logic [11:0] mem [256];
   logic [11:0] mem2 [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata  <= mem[imem_addr];
   always @(posedge clk) imem_rdata2 <= mem2[imem_addr2];

   fetch_stage #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .stop(stop), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instruction_out(instruction_out), .pc_out(pc_out), .valid_out(valid_out),
      .halted(halted), .fetch_count(fetch_count)
   );

   fetch_stage #(.ADDR_W(2), .RESET_PC(2'b00)) dut_w2 (
      .clk(clk), .reset(reset), .stop(stop2), .branch_taken(branch2),
      .branch_target(target2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .instruction_out(instr2), .pc_out(pc2), .valid_out(valid2),
      .halted(halted2), .fetch_count(count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rom();
      for (int i = 0; i < 256; i++) mem[i] = 12'h000;
      mem[0] = 12'h111;
      mem[1] = 12'h222;
      mem[2] = 12'h333;
      mem[3] = 12'h444;
      mem[8] = 12'hABC;
      mem[9] = 12'hFFF;
      for (int i = 0; i < 4; i++) mem2[i] = 12'h500 + 12'(i);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stop = 1'b0;
      branch_taken = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stop = 1'b1;
      branch_taken = 1'b1;
      branch_target = 8'h55;
      tick();
      reset = 1'b0;
      stop = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_imem_addr got %h want 00", imem_addr); end
      n_checks++;
      if (instruction_out !== 12'h000) begin n_fail++; $display("FAIL reset_instr got %h want 000", instruction_out); end
      n_checks++;
      if (pc_out !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", pc_out); end
      n_checks++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
      n_checks++;
      if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
      n_checks++;
      if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fetch_count); end
      tick();
   endtask

   task automatic test_run();
      logic [11:0] exp_i [3];
      exp_i = '{12'h111, 12'h222, 12'h333};
      do_reset();
      @(negedge clk);
      n_checks++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL run_first_valid got %b want 0", valid_out); end
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (instruction_out !== exp_i[i] || pc_out !== 8'(i) || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL run_seq[%0d] got instr=%h pc=%h v=%b want instr=%h pc=%h v=1",
                     i, instruction_out, pc_out, valid_out, exp_i[i], 8'(i));
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      @(negedge clk); tick();
      @(negedge clk); tick();
      stop = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (instruction_out !== 12'h222 || pc_out !== 8'h01 || valid_out !== 1'b1 || fetch_count !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d] got instr=%h pc=%h v=%b cnt=%0d want 222/01/1/1",
                     k, instruction_out, pc_out, valid_out, fetch_count);
         end
         tick();
      end
      stop = 1'b0;
      @(negedge clk);
      n_checks++;
      if (instruction_out !== 12'h222 || valid_out !== 1'b1 || fetch_count !== 16'd1) begin
         n_fail++;
         $display("FAIL stall_release got instr=%h v=%b cnt=%0d want 222/1/1", instruction_out, valid_out, fetch_count);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (instruction_out !== 12'h333 || pc_out !== 8'h02 || fetch_count !== 16'd2) begin
         n_fail++;
         $display("FAIL stall_next got instr=%h pc=%h cnt=%0d want 333/02/2", instruction_out, pc_out, fetch_count);
      end
      tick();
   endtask

   task automatic test_branch(input logic with_stop);
      do_reset();
      @(negedge clk); tick();
      @(negedge clk); tick();
      branch_taken = 1'b1;
      branch_target = 8'h08;
      stop = with_stop;
      @(negedge clk);
      n_checks++;
      if (valid_out !== 1'b0 || instruction_out !== 12'h000) begin
         n_fail++;
         $display("FAIL branch_bubble1 stop=%b got v=%b instr=%h want 0/000", with_stop, valid_out, instruction_out);
      end
      tick();
      branch_taken = 1'b0;
      stop = 1'b0;
      @(negedge clk);
      n_checks++;
      if (valid_out !== 1'b0 || instruction_out !== 12'h000) begin
         n_fail++;
         $display("FAIL branch_bubble2 stop=%b got v=%b instr=%h want 0/000", with_stop, valid_out, instruction_out);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (instruction_out !== 12'hABC || pc_out !== 8'h08 || valid_out !== 1'b1) begin
         n_fail++;
         $display("FAIL branch_target stop=%b got instr=%h pc=%h v=%b want ABC/08/1",
                  with_stop, instruction_out, pc_out, valid_out);
      end
      tick();
   endtask

   task automatic test_halt();
      int found = 0;
      do_reset();
      for (int c = 0; c < 20 && found == 0; c++) begin
         @(negedge clk);
         if (valid_out === 1'b1 && instruction_out === 12'hFFF) begin
            found = 1;
            n_checks++;
            if (pc_out !== 8'h09 || halted !== 1'b0) begin
               n_fail++;
               $display("FAIL halt_deliver got pc=%h halted=%b want 09/0", pc_out, halted);
            end
         end
         tick();
      end
      n_checks++;
      if (found == 0) begin n_fail++; $display("FAIL halt_seen got none want FFF within 20 cycles"); end
      for (int c = 0; c < 6; c++) begin
         branch_taken = c[0];
         branch_target = 8'h00;
         stop = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_checks++;
         if (halted !== 1'b1 || valid_out !== 1'b0 || instruction_out !== 12'h000 || fetch_count !== 16'd10) begin
            n_fail++;
            $display("FAIL halted_hold[%0d] got h=%b v=%b instr=%h cnt=%0d want 1/0/000/10",
                     c, halted, valid_out, instruction_out, fetch_count);
         end
         tick();
      end
      do_reset();
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset got halted=%b want 0", halted); end
      tick();
      @(negedge clk);
      n_checks++;
      if (instruction_out !== 12'h111 || pc_out !== 8'h00 || valid_out !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_restart got instr=%h pc=%h v=%b want 111/00/1", instruction_out, pc_out, valid_out);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [1:0] exp_pc [6];
      exp_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      @(negedge clk);
      n_checks++;
      if (valid2 !== 1'b0) begin n_fail++; $display("FAIL wrap_first_valid got %b want 0", valid2); end
      tick();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (pc2 !== exp_pc[c] || valid2 !== 1'b1 || instr2 !== mem2[exp_pc[c]]) begin
            n_fail++;
            $display("FAIL wrap_pc[%0d] got pc=%0d v=%b instr=%h want pc=%0d v=1 instr=%h",
                     c, pc2, valid2, instr2, exp_pc[c], mem2[exp_pc[c]]);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [7:0]  exp_next = 8'h00;
      logic [15:0] exp_count = 16'd0;
      logic        ready = 1'b0;
      logic        prev_stall = 1'b0;
      logic [20:0] prev_out = '0;
      logic        exp_valid;
      logic        in_reset;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 12'($urandom);
         if (mem[i] == 12'hFFF) mem[i] = 12'h000;
      end
      do_reset();
      for (int cyc = 0; cyc < 500; cyc++) begin
         in_reset      = ($urandom_range(0, 99) < 2);
         reset         = in_reset;
         stop          = ($urandom_range(0, 99) < 30);
         branch_taken  = ($urandom_range(0, 99) < 10);
         branch_target = 8'($urandom);
         @(negedge clk);
         if (!in_reset) begin
            exp_valid = ready && !branch_taken;
            n_checks++;
            if (valid_out !== exp_valid || (!exp_valid && instruction_out !== 12'h000)) begin
               n_fail++;
               $display("FAIL rnd_valid cyc=%0d got v=%b instr=%h want v=%b", cyc, valid_out, instruction_out, exp_valid);
            end
            if (valid_out === 1'b1) begin
               n_checks++;
               if (pc_out !== exp_next || instruction_out !== mem[pc_out]) begin
                  n_fail++;
                  $display("FAIL rnd_stream cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                           cyc, pc_out, instruction_out, exp_next, mem[exp_next]);
               end
            end
            if (prev_stall && !branch_taken) begin
               n_checks++;
               if ({instruction_out, pc_out, valid_out} !== prev_out) begin
                  n_fail++;
                  $display("FAIL rnd_stall_hold cyc=%0d got %h want %h", cyc, {instruction_out, pc_out, valid_out}, prev_out);
               end
            end
            n_checks++;
            if (fetch_count !== exp_count) begin
               n_fail++;
               $display("FAIL rnd_count cyc=%0d got %0d want %0d", cyc, fetch_count, exp_count);
            end
            if (branch_taken) begin
               exp_next = branch_target;
               ready = 1'b0;
            end else if (!stop) begin
               if (ready) begin
                  exp_next++;
                  exp_count++;
               end
               ready = 1'b1;
            end
            prev_stall = stop && !branch_taken;
            prev_out = {instruction_out, pc_out, valid_out};
         end else begin
            exp_next = 8'h00;
            exp_count = 16'd0;
            ready = 1'b0;
            prev_stall = 1'b0;
         end
         tick();
      end
      reset = 1'b0;
      stop = 1'b0;
      branch_taken = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      load_rom();
      tick();
      test_reset();
      test_run();
      test_stall();
      test_branch(1'b0);
      test_branch(1'b1);
      test_halt();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
